sdram_multiport_arbiter: RTL and testbench

//  Parametrised request arbiter and address sequencer for the SDRAM controller.

---
 rtl/sdram_arb_pkg.sv | 9 +
 rtl/sdram_port_addr_gen.sv | 22 ++
 rtl/sdram_multiport_arbiter.sv | 127 ++++++++++++
 tb/tb_sdram_multiport_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared FSM encoding, arbitration mode constants and index-width helper
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, UPDATE} arb_state_t;
  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sdram_port_addr_gen.sv
// sdram_port_addr_gen: one port's burst address register with reload and wrap-around advance
module sdram_port_addr_gen #(
  parameter int ASIZE = 23,
  parameter int LENW  = 9
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             load,
  input  logic             advance,
  input  logic [ASIZE-1:0] start_addr,
  input  logic [ASIZE-1:0] max_addr,
  input  logic [LENW-1:0]  len,
  output logic [ASIZE-1:0] addr
);
  logic [ASIZE:0] nxt;
  // one extra bit so addr+len can never wrap below max
  assign nxt = {1'b0, addr} + (ASIZE+1)'(len);
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) addr <= start_addr;
    else if (load) addr <= start_addr;
    else if (advance) addr <= (nxt < {1'b0, max_addr}) ? nxt[ASIZE-1:0] : start_addr;
endmodule

// File: rtl/sdram_multiport_arbiter.sv
// sdram_multiport_arbiter: picks one eligible read/write FIFO port, holds its burst request
// until the command core reports completion, then advances that port's address
module sdram_multiport_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int ASIZE   = 23,
  parameter int LENW    = 9,
  parameter int LVLW    = 16,
  parameter int RR_MODE = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NRD*LVLW-1:0]  RD_LEVEL,
  input  logic [NRD*ASIZE-1:0] RD_START_ADDR,
  input  logic [NRD*ASIZE-1:0] RD_MAX_ADDR,
  input  logic [NRD*LENW-1:0]  RD_LENGTH,
  input  logic [NRD-1:0]       RD_LOAD,
  input  logic [NWR*LVLW-1:0]  WR_LEVEL,
  input  logic [NWR*ASIZE-1:0] WR_START_ADDR,
  input  logic [NWR*ASIZE-1:0] WR_MAX_ADDR,
  input  logic [NWR*LENW-1:0]  WR_LENGTH,
  input  logic [NWR-1:0]       WR_LOAD,
  input  logic                 XFER_DONE,
  output logic                 REQ_VALID,
  output logic                 REQ_WRITE,
  output logic [ASIZE-1:0]     REQ_ADDR,
  output logic [LENW-1:0]      REQ_LENGTH,
  output logic [NRD-1:0]       RD_MASK,
  output logic [NWR-1:0]       WR_MASK
);
  localparam int NP = NRD + NWR;
  localparam int PW = idx_w(NP);
  localparam int CW = (LVLW > LENW) ? LVLW : LENW;
  arb_state_t state;
  logic [NP-1:0] elig, port_load, rot, oh;
  logic [ASIZE-1:0] addr [NP];
  logic [LENW-1:0] len [NP];
  logic [PW-1:0] grant, ptr, sel, off;
  logic [PW:0] sum;
  logic found, load_seen;
  // ports are numbered reads first, then writes
  for (genvar i = 0; i < NP; i++) begin : g_port
    logic [LVLW-1:0] lv;
    logic [ASIZE-1:0] st, mx;
    logic mine;
    if (i < NRD) begin : g_rd
      assign lv           = RD_LEVEL[i*LVLW +: LVLW];
      assign st           = RD_START_ADDR[i*ASIZE +: ASIZE];
      assign mx           = RD_MAX_ADDR[i*ASIZE +: ASIZE];
      assign len[i]       = RD_LENGTH[i*LENW +: LENW];
      assign port_load[i] = RD_LOAD[i];
    end else begin : g_wr
      assign lv           = WR_LEVEL[(i-NRD)*LVLW +: LVLW];
      assign st           = WR_START_ADDR[(i-NRD)*ASIZE +: ASIZE];
      assign mx           = WR_MAX_ADDR[(i-NRD)*ASIZE +: ASIZE];
      assign len[i]       = WR_LENGTH[(i-NRD)*LENW +: LENW];
      assign port_load[i] = WR_LOAD[i-NRD];
    end
    assign elig[i] = !port_load[i] && len[i] != '0 &&
                     ((i < NRD) ? (CW'(lv) < CW'(len[i])) : (CW'(lv) >= CW'(len[i])));
    assign mine = state == UPDATE && grant == PW'(i);
    // a LOAD seen while this port's burst was running turns the advance into a reload
    sdram_port_addr_gen #(.ASIZE(ASIZE), .LENW(LENW)) u_addr (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .load      (port_load[i] || (mine && load_seen)),
      .advance   (mine && !load_seen),
      .start_addr(st),
      .max_addr  (mx),
      .len       (REQ_LENGTH),
      .addr      (addr[i])
    );
  end
  assign rot = NP'({elig, elig} >> ptr);
  assign oh  = NP'(1) << sel;
  always_comb begin
    found = 1'b0;
    off = '0;
    for (int k = NP-1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        off = PW'(k);
      end
    sum = {1'b0, ptr} + {1'b0, off};
    sel = (sum >= (PW+1)'(NP)) ? PW'(sum - (PW+1)'(NP)) : PW'(sum);
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state      <= IDLE;
      grant      <= '0;
      ptr        <= '0;
      load_seen  <= 1'b0;
      REQ_VALID  <= 1'b0;
      REQ_WRITE  <= 1'b0;
      REQ_ADDR   <= '0;
      REQ_LENGTH <= '0;
      RD_MASK    <= '0;
      WR_MASK    <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          state      <= BUSY;
          grant      <= sel;
          load_seen  <= 1'b0;
          ptr        <= (RR_MODE == RR_ROUND && sel != PW'(NP-1)) ? sel + 1'b1 : '0;
          REQ_VALID  <= 1'b1;
          REQ_WRITE  <= sel >= PW'(NRD);
          REQ_ADDR   <= addr[sel];
          REQ_LENGTH <= len[sel];
          RD_MASK    <= oh[NRD-1:0];
          WR_MASK    <= oh[NP-1:NRD];
        end
        BUSY: begin
          if (port_load[grant]) load_seen <= 1'b1;
          if (XFER_DONE) begin
            state     <= UPDATE;
            REQ_VALID <= 1'b0;
            RD_MASK   <= '0;
            WR_MASK   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sdram_multiport_arbiter.sv
// tb_sdram_multiport_arbiter: directed scenarios plus randomized bursts against a burst-level model,
// run on a round-robin instance (d=0) and a fixed-priority instance (d=1)
module tb_sdram_multiport_arbiter;
  localparam int NRD = 2, NWR = 2, NP = NRD + NWR, ASIZE = 23, LENW = 9, LVLW = 16;
  logic CLK = 1'b0, RESET_N = 1'b0;
  logic [LVLW-1:0] lvl [NP];
  logic [ASIZE-1:0] st [NP], mx [NP];
  logic [LENW-1:0] ln [NP];
  logic ld [NP];
  logic [NRD*LVLW-1:0] rd_level;
  logic [NRD*ASIZE-1:0] rd_start, rd_max;
  logic [NRD*LENW-1:0] rd_len;
  logic [NRD-1:0] rd_load;
  logic [NWR*LVLW-1:0] wr_level;
  logic [NWR*ASIZE-1:0] wr_start, wr_max;
  logic [NWR*LENW-1:0] wr_len;
  logic [NWR-1:0] wr_load;
  logic xfer_done [2];
  logic req_valid [2], req_write [2];
  logic [ASIZE-1:0] req_addr [2];
  logic [LENW-1:0] req_length [2];
  logic [NRD-1:0] rd_mask [2];
  logic [NWR-1:0] wr_mask [2];
  int total = 0, bad = 0;

  always #5 CLK = ~CLK;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign rd_level[i*LVLW +: LVLW] = lvl[i];
    assign rd_start[i*ASIZE +: ASIZE] = st[i];
    assign rd_max[i*ASIZE +: ASIZE] = mx[i];
    assign rd_len[i*LENW +: LENW] = ln[i];
    assign rd_load[i] = ld[i];
  end
  for (genvar i = 0; i < NWR; i++) begin : g_wr
    assign wr_level[i*LVLW +: LVLW] = lvl[NRD+i];
    assign wr_start[i*ASIZE +: ASIZE] = st[NRD+i];
    assign wr_max[i*ASIZE +: ASIZE] = mx[NRD+i];
    assign wr_len[i*LENW +: LENW] = ln[NRD+i];
    assign wr_load[i] = ld[NRD+i];
  end

  for (genvar d = 0; d < 2; d++) begin : g_dut
    sdram_multiport_arbiter #(.NRD(NRD), .NWR(NWR), .ASIZE(ASIZE), .LENW(LENW), .LVLW(LVLW),
                              .RR_MODE(d == 0 ? 1 : 0)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .RD_LEVEL(rd_level), .RD_START_ADDR(rd_start), .RD_MAX_ADDR(rd_max),
      .RD_LENGTH(rd_len), .RD_LOAD(rd_load),
      .WR_LEVEL(wr_level), .WR_START_ADDR(wr_start), .WR_MAX_ADDR(wr_max),
      .WR_LENGTH(wr_len), .WR_LOAD(wr_load),
      .XFER_DONE(xfer_done[d]),
      .REQ_VALID(req_valid[d]), .REQ_WRITE(req_write[d]), .REQ_ADDR(req_addr[d]),
      .REQ_LENGTH(req_length[d]), .RD_MASK(rd_mask[d]), .WR_MASK(wr_mask[d])
    );
  end

  function automatic logic [NP-1:0] exp_mask(input int p);
    logic [NP-1:0] one = 1;
    return one << p;
  endfunction

  function automatic bit m_elig(input int p);
    return ld[p] == 1'b0 && ln[p] != 0 && (p < NRD ? lvl[p] < ln[p] : lvl[p] >= ln[p]);
  endfunction

  task automatic set_port(input int p, input int level, input int len, input int start, input int max);
    lvl[p] = LVLW'(level);
    ln[p]  = LENW'(len);
    st[p]  = ASIZE'(start);
    mx[p]  = ASIZE'(max);
    ld[p]  = 1'b0;
  endtask

  task automatic all_idle;
    for (int p = 0; p < NP; p++) set_port(p, 0, 0, 0, 0);
  endtask

  task automatic do_reset;
    xfer_done[0] = 1'b0;
    xfer_done[1] = 1'b0;
    RESET_N = 1'b0;
    @(posedge CLK);
    #1 RESET_N = 1'b1;
  endtask

  task automatic wait_grant(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK);
      #1;
      if (req_valid[d]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic done_pulse(input int d);
    repeat (2) @(posedge CLK);
    #1 xfer_done[d] = 1'b1;
    @(posedge CLK);
    #1 xfer_done[d] = 1'b0;
  endtask

  task automatic test_reset;
    all_idle();
    set_port(0, 0, 256, 'h123, 'h7fffff);
    xfer_done[0] = 1'b0;
    xfer_done[1] = 1'b0;
    RESET_N = 1'b0;
    @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({req_valid[d], req_write[d], rd_mask[d], wr_mask[d], req_addr[d], req_length[d]} !== '0) begin
        bad++;
        $display("FAIL reset_state d=%0d got valid=%b mask=%b%b addr=%h len=%0d exp all zero",
                 d, req_valid[d], wr_mask[d], rd_mask[d], req_addr[d], req_length[d]);
      end
    end
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({req_valid[d], req_write[d], wr_mask[d], rd_mask[d], req_addr[d], req_length[d]} !==
          {1'b1, 1'b0, 4'b0001, 23'h123, 9'd256}) begin
        bad++;
        $display("FAIL first_grant d=%0d got valid=%b wr=%b mask=%b%b addr=%h len=%0d exp 1 0 0001 123 256",
                 d, req_valid[d], req_write[d], wr_mask[d], rd_mask[d], req_addr[d], req_length[d]);
      end
    end
  endtask

  task automatic setup_all_eligible;
    all_idle();
    for (int p = 0; p < NP; p++) set_port(p, p < NRD ? 0 : 9, 4, p * 'h1000, p * 'h1000 + 'h800);
    do_reset();
  endtask

  task automatic test_round_robin;
    bit ok;
    int seq [5] = '{0, 1, 2, 3, 0};
    setup_all_eligible();
    for (int b = 0; b < 5; b++) begin
      wait_grant(0, ok);
      total++;
      if (!ok || {wr_mask[0], rd_mask[0]} !== exp_mask(seq[b]) || req_write[0] !== (seq[b] >= NRD)) begin
        bad++;
        $display("FAIL rr_grant%0d got ok=%b mask=%b wr=%b exp mask=%b", b, ok,
                 {wr_mask[0], rd_mask[0]}, req_write[0], exp_mask(seq[b]));
      end
      done_pulse(0);
    end
  endtask

  task automatic test_fixed_priority;
    bit ok;
    setup_all_eligible();
    for (int b = 0; b < 5; b++) begin
      wait_grant(1, ok);
      total++;
      if (!ok || {wr_mask[1], rd_mask[1]} !== exp_mask(0) || req_addr[1] !== ASIZE'(4 * b)) begin
        bad++;
        $display("FAIL fixed_grant%0d got ok=%b mask=%b addr=%h exp mask=0001 addr=%h", b, ok,
                 {wr_mask[1], rd_mask[1]}, req_addr[1], 4 * b);
      end
      done_pulse(1);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    int exp_a [5] = '{0, 256, 512, 768, 0};
    all_idle();
    set_port(0, 0, 256, 0, 1024);
    do_reset();
    for (int b = 0; b < 5; b++) begin
      wait_grant(0, ok);
      total++;
      if (!ok || req_addr[0] !== ASIZE'(exp_a[b])) begin
        bad++;
        $display("FAIL wrap_addr%0d got ok=%b addr=%0d exp %0d", b, ok, req_addr[0], exp_a[b]);
      end
      done_pulse(0);
    end
  endtask

  task automatic test_load_during_busy;
    bit ok;
    all_idle();
    set_port(0, 0, 16, 'h40, 'h10000);
    do_reset();
    wait_grant(0, ok);
    total++;
    if (!ok || req_addr[0] !== 23'h40) begin
      bad++;
      $display("FAIL load_first got ok=%b addr=%h exp 40", ok, req_addr[0]);
    end
    @(posedge CLK);
    #1 ld[0] = 1'b1;
    @(posedge CLK);
    #1 ld[0] = 1'b0;
    total++;
    if (req_valid[0] !== 1'b1 || rd_mask[0] !== 2'b01) begin
      bad++;
      $display("FAIL load_hold got valid=%b mask=%b exp 1 01", req_valid[0], rd_mask[0]);
    end
    xfer_done[0] = 1'b1;
    @(posedge CLK);
    #1 xfer_done[0] = 1'b0;
    wait_grant(0, ok);
    total++;
    if (!ok || req_addr[0] !== 23'h40) begin
      bad++;
      $display("FAIL load_reload got ok=%b addr=%h exp 40", ok, req_addr[0]);
    end
    done_pulse(0);
    wait_grant(0, ok);
    total++;
    if (!ok || req_addr[0] !== 23'h50) begin
      bad++;
      $display("FAIL load_advance got ok=%b addr=%h exp 50", ok, req_addr[0]);
    end
    done_pulse(0);
  endtask

  task automatic test_reset_abort;
    bit ok;
    all_idle();
    set_port(0, 0, 8, 'h200, 'h10000);
    do_reset();
    wait_grant(0, ok);
    #3 RESET_N = 1'b0;
    #1;
    total++;
    if (!ok || req_valid[0] !== 1'b0 || rd_mask[0] !== '0 || wr_mask[0] !== '0) begin
      bad++;
      $display("FAIL abort_async got ok=%b valid=%b mask=%b%b exp 1 0 0000", ok, req_valid[0],
               wr_mask[0], rd_mask[0]);
    end
    ln[0] = '0;
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    xfer_done[0] = 1'b1;
    @(posedge CLK);
    #1 xfer_done[0] = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (req_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle got valid=%b exp 0", req_valid[0]);
    end
    ln[0] = 9'd8;
    wait_grant(0, ok);
    total++;
    if (!ok || req_addr[0] !== 23'h200) begin
      bad++;
      $display("FAIL abort_regrant got ok=%b addr=%h exp 200", ok, req_addr[0]);
    end
    done_pulse(0);
    wait_grant(0, ok);
    total++;
    if (!ok || req_addr[0] !== 23'h208) begin
      bad++;
      $display("FAIL abort_next got ok=%b addr=%h exp 208", ok, req_addr[0]);
    end
    done_pulse(0);
  endtask

  task automatic rand_port(input int p);
    int s = $urandom_range(0, 50);
    set_port(p, $urandom_range(0, 8), $urandom_range(0, 7), s, s + $urandom_range(0, 60));
  endtask

  task automatic test_random(input int d, input int n);
    bit ok, rr;
    int ma [NP];
    int ptr, w;
    rr = (d == 0);
    for (int p = 0; p < NP; p++) rand_port(p);
    do_reset();
    for (int p = 0; p < NP; p++) ma[p] = int'(st[p]);
    ptr = 0;
    for (int it = 0; it < n; it++) begin
      w = -1;
      for (int k = 0; k < NP; k++) begin
        int p = rr ? (ptr + k) % NP : k;
        if (w < 0 && m_elig(p)) w = p;
      end
      wait_grant(d, ok);
      total++;
      if (w < 0) begin
        if (ok) begin
          bad++;
          $display("FAIL rnd_idle d=%0d it=%0d got unexpected grant mask=%b", d, it, {wr_mask[d], rd_mask[d]});
          break;
        end
        for (int p = 0; p < NP; p++) rand_port(p);
        continue;
      end
      if (!ok || {wr_mask[d], rd_mask[d]} !== exp_mask(w) || req_addr[d] !== ASIZE'(ma[w]) ||
          req_length[d] !== ln[w] || req_write[d] !== (w >= NRD)) begin
        bad++;
        $display("FAIL rnd_grant d=%0d it=%0d got ok=%b mask=%b addr=%0d len=%0d wr=%b exp mask=%b addr=%0d len=%0d",
                 d, it, ok, {wr_mask[d], rd_mask[d]}, req_addr[d], req_length[d], req_write[d],
                 exp_mask(w), ma[w], ln[w]);
        if (!ok) break;
      end
      for (int p = 0; p < NP; p++) if (p != w) rand_port(p);
      lvl[w] = LVLW'($urandom_range(0, 8));
      done_pulse(d);
      ma[w] = (ma[w] + int'(ln[w]) < int'(mx[w])) ? ma[w] + int'(ln[w]) : int'(st[w]);
      if (rr) ptr = (w + 1) % NP;
    end
    xfer_done[d] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_wrap();
    test_load_during_busy();
    test_reset_abort();
    test_random(0, 60);
    test_random(1, 60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
